// File: rtl/serial_cmd_transmitter.sv
// rtl/serial_cmd_transmitter.sv - command FIFO, 3-slot serial framer and shadow accumulator
//
// Purpose:
//   Accepts 2-bit accumulator commands (00 NOP, 01 INC, 11 LOAD8, 10 reserved)
//   over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It
//   sends one command per fixed 3-cycle frame on the serial control line:
//   slot 0 carries bit0, slot 1 carries bit1, and slot 2 is a gap driven to 0.
//   A shadow accumulator predicts the remote ACC, so upstream logic can read
//   it without a return path.
//
// Ports:
//   CLK          in   clock, all state updates on the rising edge
//   RST          in   asynchronous active-low reset
//   cmd_valid    in   upstream presents a command
//   cmd[1:0]     in   command code
//   cmd_ready    out  FIFO not full
//   cmd_err      out  one-cycle pulse after a reserved code is accepted
//   control      out  registered serial line to the accumulator
//   frame_start  out  control currently carries bit0 of a frame
//   shadow_acc   out  predicted remote ACC
//   shadow_zero  out  shadow_acc == 0
//   fifo_level   out  occupied FIFO entries
//   idle         out  FIFO empty and current frame is NOP

module serial_cmd_transmitter #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic                     cmd_err,
    output logic                     control,
    output logic                     frame_start,
    output logic [3:0]               shadow_acc,
    output logic                     shadow_zero,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Slot the receiver samples at the next rising edge. It runs freely,
    // so receiver alignment depends only on a common reset release.
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2
    } slot_t;

    slot_t          r_slot;
    slot_t          w_slot_nxt;
    logic [1:0]     r_cur;
    logic [1:0]     w_cur_nxt;
    logic           r_control;
    logic           w_control_nxt;
    logic [3:0]     r_shadow;
    logic [3:0]     w_shadow_nxt;
    logic           r_cmd_err;

    logic [1:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_ready;
    logic           w_push;
    logic           w_pop;
    logic           w_reserved;
    logic [1:0]     w_wdata;

    // Handshake and FIFO control
    assign w_ready    = (r_count != LEVEL_FULL);
    assign w_push     = cmd_valid && w_ready;
    assign w_reserved = (cmd == 2'b10);
    // A reserved code is stored as NOP so the line never carries 10.
    assign w_wdata    = w_reserved ? 2'b00 : cmd;
    // The FIFO is popped only at the frame boundary. A push on the same edge
    // is not visible yet, so commands are never bypassed into the frame in flight.
    assign w_pop      = (r_slot == SLOT2) && (r_count != '0);

    // Frame sequencing and the shadow update
    always_comb begin
        w_slot_nxt    = r_slot;
        w_cur_nxt     = r_cur;
        w_control_nxt = r_control;
        w_shadow_nxt  = r_shadow;
        case (r_slot)
            SLOT0: begin
                w_control_nxt = r_cur[1];
                w_slot_nxt    = SLOT1;
            end
            SLOT1: begin
                w_control_nxt = 1'b0;
                w_slot_nxt    = SLOT2;
            end
            SLOT2: begin
                // The receiver evaluates the completed frame on this edge,
                // so the shadow follows it on the same edge.
                case (r_cur)
                    2'b01:   w_shadow_nxt = r_shadow + 4'd1;
                    2'b11:   w_shadow_nxt = 4'd8;
                    default: w_shadow_nxt = r_shadow;
                endcase
                w_cur_nxt     = w_pop ? r_mem[r_rd_ptr] : 2'b00;
                w_control_nxt = w_cur_nxt[0];
                w_slot_nxt    = SLOT0;
            end
            default: begin
                // The unused slot encoding recovers to a clean frame boundary.
                w_cur_nxt     = 2'b00;
                w_control_nxt = 1'b0;
                w_slot_nxt    = SLOT0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_slot    <= SLOT0;
            r_cur     <= 2'b00;
            r_control <= 1'b0;
            r_shadow  <= 4'd0;
        end else begin
            r_slot    <= w_slot_nxt;
            r_cur     <= w_cur_nxt;
            r_control <= w_control_nxt;
            r_shadow  <= w_shadow_nxt;
        end
    end

    // FIFO storage holds no reset: the pointers define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LEVEL_ONE;
                2'b01:   r_count <= r_count - LEVEL_ONE;
                default: r_count <= r_count;
            endcase
            r_cmd_err <= w_push && w_reserved;
        end
    end

    // Outputs
    assign cmd_ready   = w_ready;
    assign cmd_err     = r_cmd_err;
    assign control     = r_control;
    assign frame_start = (r_slot == SLOT0);
    assign shadow_acc  = r_shadow;
    assign shadow_zero = (r_shadow == 4'd0);
    assign fifo_level  = r_count;
    assign idle        = (r_count == '0) && (r_cur == 2'b00);

endmodule
